pmac_dp: RTL and testbench

- Bit-serial multiply-accumulate datapath; sits directly downstream of the node packet controller.
- Consumes the controller's 3-bit opcode and the shared serial line rx, and drives the node's serial output tx.
- Holds two operand registers and one result register; supports daisy-chained load, readback and serial accumulation of results across nodes.

---
 rtl/pmac_pkg.sv | 13 +
 rtl/pmac_mul.sv | 79 +++++++
 rtl/pmac_dp.sv | 99 +++++++++
 tb/tb_pmac_dp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pmac_pkg.sv
// rtl/pmac_pkg.sv - opcodes and widths shared by the packet controller and the MAC datapath
package pmac_pkg;
    localparam int DW_DEFAULT = 16;

    localparam logic [2:0] OUT_DATA1   = 3'd0;
    localparam logic [2:0] OUT_DATA2   = 3'd1;
    localparam logic [2:0] OUT_RES     = 3'd2;
    localparam logic [2:0] OUT_RES_ADD = 3'd3;
    localparam logic [2:0] LOAD_RES    = 3'd4;
    localparam logic [2:0] MUL         = 3'd5;
    localparam logic [2:0] MUL_ADD     = 3'd6;
    localparam logic [2:0] NO_OP       = 3'd7;
endpackage

// File: rtl/pmac_mul.sv
// rtl/pmac_mul.sv - sequential shift-add multiplier, one multiplier bit per cycle
module pmac_mul
    import pmac_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = 2 * DW
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          start,
    input  logic [RW-1:0] acc_init,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] product
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] acc_q, acc_d;
    logic [RW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [RW-1:0] acc_nxt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done     = 1'b0;
        acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = acc_init;
                    mcand_d  = {{(RW-DW){1'b0}}, a};
                    mplier_d = b;
                    cnt_d    = CW'(DW);
                    state_d  = RUN;
                end
            end
            default: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Final iteration hands its sum straight out so res lands DW+1 cycles after start
                if (cnt_q == CW'(1)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign busy    = (state_q == RUN);
    assign product = acc_nxt;
endmodule

// File: rtl/pmac_dp.sv
// rtl/pmac_dp.sv - bit-serial MAC datapath: daisy-chained operand/result shifting, serial add, multiply
module pmac_dp
    import pmac_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = 2 * DW
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic [2:0]    opcode,
    input  logic          rx,
    output logic          tx,
    output logic          busy,
    output logic [RW-1:0] res_q
);
    logic [DW-1:0] data1_q, data1_d;
    logic [DW-1:0] data2_q, data2_d;
    logic [RW-1:0] res_d;
    logic          carry_q, carry_d;
    logic          tx_q, tx_d;
    logic [2:0]    prev_op_q;
    logic          cin;
    logic          mul_start, mul_busy, mul_done;
    logic [RW-1:0] mul_product;

    assign mul_start = !mul_busy && (opcode == MUL || opcode == MUL_ADD);

    pmac_mul #(.DW(DW), .RW(RW)) u_mul (
        .clk      (clk),
        .nRst     (nRst),
        .start    (mul_start),
        .acc_init ((opcode == MUL_ADD) ? res_q : '0),
        .a        (data1_q),
        .b        (data2_q),
        .busy     (mul_busy),
        .done     (mul_done),
        .product  (mul_product)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            data1_q   <= '0;
            data2_q   <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            tx_q      <= 1'b1;
            prev_op_q <= NO_OP;
        end else begin
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            tx_q      <= tx_d;
            prev_op_q <= opcode;
        end
    end

    // A fresh add window starts with no carry-in
    assign cin = (prev_op_q == OUT_RES_ADD) ? carry_q : 1'b0;

    always_comb begin
        data1_d = data1_q;
        data2_d = data2_q;
        res_d   = res_q;
        carry_d = carry_q;
        tx_d    = 1'b1;
        if (mul_done) begin
            res_d = mul_product;
        end else if (!mul_busy) begin
            case (opcode)
                OUT_DATA1: begin
                    tx_d    = data1_q[0];
                    data1_d = {rx, data1_q[DW-1:1]};
                end
                OUT_DATA2: begin
                    tx_d    = data2_q[0];
                    data2_d = {rx, data2_q[DW-1:1]};
                end
                OUT_RES: begin
                    tx_d  = res_q[0];
                    res_d = {rx, res_q[RW-1:1]};
                end
                OUT_RES_ADD: begin
                    tx_d    = res_q[0] ^ rx ^ cin;
                    carry_d = (res_q[0] & rx) | (res_q[0] & cin) | (rx & cin);
                    res_d   = {rx, res_q[RW-1:1]};
                end
                LOAD_RES: begin
                    tx_d  = rx;
                    res_d = {rx, res_q[RW-1:1]};
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = mul_busy;
endmodule

// File: tb/tb_pmac_dp.sv
// tb/tb_pmac_dp.sv - directed and randomized checks of pmac_dp against an arithmetic reference model
module tb_pmac_dp;
    import pmac_pkg::*;

    logic        clk;
    logic        nRst;
    logic [2:0]  opcode;
    logic        rx;
    logic        tx;
    logic        busy;
    logic [31:0] res_q;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_d1, m_d2;
    logic [31:0] m_res;
    logic [31:0] sout;
    logic [31:0] rv;
    logic [15:0] ra, rb;

    pmac_dp dut (
        .clk    (clk),
        .nRst   (nRst),
        .opcode (opcode),
        .rx     (rx),
        .tx     (tx),
        .busy   (busy),
        .res_q  (res_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic shift(input logic [2:0] op, input int n, input logic [31:0] din,
                         output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            opcode = op;
            rx     = din[i];
            @(posedge clk);
            #1;
            dout[i] = tx;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            opcode = NO_OP;
            rx     = 1'($urandom);
        end
    endtask

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] o;
        shift(OUT_DATA1, 16, {16'h0, a}, o);
        chk("data1_readback", o, {16'h0, m_d1});
        m_d1 = a;
        shift(OUT_DATA2, 16, {16'h0, b}, o);
        chk("data2_readback", o, {16'h0, m_d2});
        m_d2 = b;
        idle(1);
    endtask

    task automatic load_res(input logic [31:0] v);
        logic [31:0] o;
        shift(LOAD_RES, 32, v, o);
        chk("load_res_passthru", o, v);
        chk("load_res_value", res_q, v);
        m_res = v;
        idle(1);
    endtask

    // Launch a multiply and keep hammering random opcodes while busy; all must be ignored
    task automatic do_mul(input logic [2:0] op);
        int n;
        logic tx_bad;
        logic [31:0] prod;
        prod = {16'h0, m_d1} * {16'h0, m_d2};
        @(negedge clk);
        opcode = op;
        @(posedge clk);
        #1;
        n = 0;
        tx_bad = 1'b0;
        while (busy && n < 40) begin
            @(negedge clk);
            opcode = 3'($urandom_range(0, 7));
            rx     = 1'($urandom);
            @(posedge clk);
            #1;
            if (tx !== 1'b1) tx_bad = 1'b1;
            n++;
        end
        chk("mul_busy_cycles", 32'(n), 32'd16);
        chk("mul_tx_idle_while_busy", {31'h0, tx_bad}, 32'h0);
        m_res = (op == MUL_ADD) ? m_res + prod : prod;
        chk("mul_result", res_q, m_res);
        idle(1);
    endtask

    initial begin
        nRst   = 1'b0;
        opcode = NO_OP;
        rx     = 1'b0;
        m_d1   = '0;
        m_d2   = '0;
        m_res  = '0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            opcode = 3'($urandom_range(0, 7));
            rx     = 1'($urandom);
            @(posedge clk);
            #1;
            chk("reset_tx", {31'h0, tx}, 32'h1);
            chk("reset_busy", {31'h0, busy}, 32'h0);
            chk("reset_res", res_q, 32'h0);
        end
        @(negedge clk);
        opcode = NO_OP;
        nRst   = 1'b1;
        idle(3);
        @(posedge clk);
        #1;
        chk("noop_tx", {31'h0, tx}, 32'h1);
        chk("noop_res", res_q, 32'h0);

        shift(OUT_DATA1, 16, 32'h1234, sout);
        chk("data1_first_out", sout, 32'h0);
        shift(OUT_DATA1, 16, 32'h0, sout);
        chk("data1_second_out", sout, 32'h1234);
        idle(1);

        load_ops(16'h00FF, 16'h0101);
        do_mul(MUL);
        chk("mul_dir_value", res_q, 32'h0000FFFF);

        load_res(32'h00000001);
        load_ops(16'hFFFF, 16'hFFFF);
        do_mul(MUL_ADD);
        chk("muladd_dir_value", res_q, 32'hFFFE0002);

        for (int k = 0; k < 4; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            load_ops(ra, rb);
            do_mul((k % 2 == 0) ? MUL : MUL_ADD);
        end

        load_res(32'hFFFFFFFF);
        shift(OUT_RES_ADD, 32, 32'h00000001, sout);
        chk("add_wrap_sum", sout, 32'h00000000);
        chk("add_wrap_res", res_q, 32'h00000001);
        m_res = 32'h00000001;
        idle(1);
        for (int k = 0; k < 3; k++) begin
            rv = $urandom;
            shift(OUT_RES_ADD, 32, rv, sout);
            chk("add_rand_sum", sout, m_res + rv);
            chk("add_rand_res", res_q, rv);
            m_res = rv;
            idle(1);
        end

        load_res(32'hDEADBEEF);
        rv = $urandom;
        shift(OUT_RES, 32, rv, sout);
        chk("out_res_stream", sout, 32'hDEADBEEF);
        chk("out_res_reload", res_q, rv);
        m_res = rv;
        idle(1);

        load_ops(16'hABCD, 16'h1357);
        @(negedge clk);
        opcode = MUL;
        @(negedge clk);
        opcode = NO_OP;
        repeat (5) @(negedge clk);
        chk("mid_mul_busy", {31'h0, busy}, 32'h1);
        nRst = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_res", res_q, 32'h0);
        chk("abort_tx", {31'h0, tx}, 32'h1);
        @(negedge clk);
        nRst  = 1'b1;
        m_d1  = '0;
        m_d2  = '0;
        m_res = '0;
        idle(2);
        load_ops(16'h0F0F, 16'h00F3);
        do_mul(MUL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
